// File: rtl/operand_capture_bank.sv
// -----------------------------------------------------------------------------
// operand_capture_bank
//
// Collects NUM_OPS operands of WIDTH bits, one per accepted transfer, from a
// shared input bus and presents the complete set to the logic unit as a single
// packed bus. Two states: COLLECT accepts operands into consecutive slots, FULL
// holds the set until the consumer takes it. There is no bypass: a new set can
// only start loading in the cycle after the output handshake.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset (highest priority)
//   clr        synchronous flush of the current set, zeroes all slots
//   in_valid   in_data holds an operand to load
//   in_ready   block can accept an operand this cycle (state == COLLECT)
//   in_data    operand value
//   load_idx   slot the next accepted operand is written to
//   out_valid  ops_data holds a complete operand set (registered)
//   out_ready  consumer accepts the set this cycle
//   ops_data   packed slots, slot k at [k*WIDTH +: WIDTH]
// -----------------------------------------------------------------------------
module operand_capture_bank #(
  parameter int WIDTH   = 6,
  parameter int NUM_OPS = 2,
  parameter int IDX_W   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic [IDX_W-1:0]         load_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_OPS*WIDTH-1:0] ops_data
);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

  state_t           state_p0;
  logic [WIDTH-1:0] slot_p0 [NUM_OPS];

  // Index that follows the current one; wraps to slot 0 after the last slot,
  // which also keeps a single-slot bank pinned at index 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == LAST_IDX) begin
      next_idx = '0;
    end else begin
      next_idx = idx + IDX_W'(1);
    end
  endfunction

  logic xfer_in;
  logic xfer_out;

  assign in_ready = (state_p0 == COLLECT);
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  // Stage p0: slot bank and control. rst and clr share one path because both
  // abandon the set and zero the slots; any handshake on that edge is dropped.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_p0  <= COLLECT;
      load_idx  <= '0;
      out_valid <= 1'b0;
      for (int k = 0; k < NUM_OPS; k++) begin
        slot_p0[k] <= '0;
      end
    end else begin
      case (state_p0)
        COLLECT: begin
          if (xfer_in) begin
            for (int k = 0; k < NUM_OPS; k++) begin
              if (load_idx == IDX_W'(k)) begin
                slot_p0[k] <= in_data;
              end
            end
            load_idx <= next_idx(load_idx);
            if (load_idx == LAST_IDX) begin
              state_p0  <= FULL;
              out_valid <= 1'b1;
            end
          end
        end
        FULL: begin
          // Slots are kept on handoff; only the next load overwrites them.
          if (xfer_out) begin
            state_p0  <= COLLECT;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_p0  <= COLLECT;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Fixed packing: slot k always lands at the same bit position.
  always_comb begin
    ops_data = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      ops_data[k*WIDTH +: WIDTH] = slot_p0[k];
    end
  end

endmodule
